rle1_dec: RTL

RLE1_DEC -- requirements
Module: rle1_dec

---
 rtl/rle1_pkg.sv | 16 +
 rtl/rle1_dec.sv | 104 ++++++++++
 2 files changed

// File: rtl/rle1_pkg.sv
// Shared definitions for the 1-bit run-length codec: field widths, packed-pair
// bit positions and the decoder FSM state type.
package rle1_pkg;

  localparam int COUNT_W   = 4;
  localparam int SYM_W     = 1;
  localparam int SYM_BIT   = 0;
  localparam int COUNT_LSB = SYM_BIT + SYM_W;
  localparam int LAST_BIT  = COUNT_LSB + COUNT_W;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/rle1_dec.sv
// Run-length decoder: expands {last, count, symbol} pairs into a stream of
// symbols, one per cycle, with last marking the final symbol of a flagged pair.
module rle1_dec #(
  parameter int COUNT_W = rle1_pkg::COUNT_W,
  parameter int SYM_W   = rle1_pkg::SYM_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COUNT_W+SYM_W:0]     rle1__input_r,
  input  logic                       rle1__input_r_vld,
  output logic                       rle1__input_r_rdy,
  output logic [SYM_W:0]             rle1__output_s,
  output logic                       rle1__output_s_vld,
  input  logic                       rle1__output_s_rdy
);

  import rle1_pkg::*;

  state_t               state;
  state_t               next_state;
  logic [COUNT_W-1:0]   remaining;
  logic [SYM_W-1:0]     sym;
  logic                 last;

  logic [COUNT_W-1:0]   in_count;
  logic [SYM_W-1:0]     in_sym;
  logic                 in_last;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 load;
  logic                 final_sym;

  assign in_sym    = rle1__input_r[SYM_W-1:0];
  assign in_count  = rle1__input_r[SYM_W +: COUNT_W];
  assign in_last   = rle1__input_r[COUNT_W+SYM_W];

  assign in_xfer   = rle1__input_r_vld & rle1__input_r_rdy;
  assign out_xfer  = rle1__output_s_vld & rle1__output_s_rdy;
  assign load      = in_xfer & (in_count != '0);
  assign final_sym = (remaining == COUNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero-count pair is consumed without leaving IDLE; in EMIT an input can
  // only transfer together with the final output symbol.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load) next_state = EMIT;
      end
      EMIT: begin
        if (out_xfer && final_sym) next_state = load ? EMIT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ready in IDLE is gated by reset so it stays low while reset is held.
  always_comb begin
    rle1__input_r_rdy  = 1'b0;
    rle1__output_s_vld = 1'b0;
    rle1__output_s     = '0;
    case (state)
      IDLE: begin
        rle1__input_r_rdy = reset;
      end
      EMIT: begin
        rle1__input_r_rdy  = final_sym & rle1__output_s_rdy;
        rle1__output_s_vld = 1'b1;
        rle1__output_s     = {last & final_sym, sym};
      end
      default: begin
        rle1__input_r_rdy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      sym       <= '0;
      last      <= 1'b0;
    end else if (load) begin
      remaining <= in_count;
      sym       <= in_sym;
      last      <= in_last;
    end else if (out_xfer) begin
      if (final_sym) begin
        remaining <= '0;
        last      <= 1'b0;
      end else begin
        remaining <= remaining - COUNT_W'(1);
      end
    end
  end

endmodule
